// File: rtl/gyro_heading_integ.sv
// gyro_heading_integ: offset-calibrated yaw-rate integrator producing a wrapping 12-bit heading
module gyro_heading_integ #(
   parameter bit FAST_SIM  = 1'b1,
   parameter int FUS_SHIFT = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               strt_cal,
   input  logic               vld,
   input  logic signed [15:0] yaw_rt,
   input  logic               moving,
   input  logic               en_fusion,
   input  logic signed [8:0]  IR_Dtrm,
   output logic               cal_done,
   output logic               rdy,
   output logic [11:0]        heading
);
   localparam int N    = FAST_SIM ? 8 : 11;
   localparam int LAST = (1 << N) - 1;
   typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;
   state_t state, state_nxt;
   logic signed [26:0] cal_acc, cal_sum, heading_acc, acc_nxt, fus;
   logic signed [16:0] diff;
   logic signed [15:0] offset, comp, comp_nxt;
   logic signed [8:0]  s1_ir;
   logic [N:0]         count;
   logic               cal_last, take, s1_vld, s1_moving, s1_fusion;
   // strt_cal always wins; the last calibration sample moves us to RUN
   always_comb begin
      cal_last  = state == CAL && vld && !strt_cal && count == LAST[N:0];
      take      = s1_vld && !strt_cal;
      state_nxt = strt_cal ? CAL : cal_last ? RUN : state;
   end
   // offset compensation with saturation, fusion term and heading sum
   always_comb begin
      cal_sum  = cal_acc + {{11{yaw_rt[15]}}, yaw_rt};
      diff     = {yaw_rt[15], yaw_rt} - {offset[15], offset};
      comp_nxt = (diff[16] != diff[15]) ? (diff[16] ? 16'sh8000 : 16'sh7FFF) : diff[15:0];
      fus      = s1_fusion ? {{18{s1_ir[8]}}, s1_ir} <<< FUS_SHIFT : '0;
      acc_nxt  = heading_acc + {{11{comp[15]}}, comp} + fus;
   end
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   // calibration sum and sample count, cleared on every (re)start
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cal_acc <= '0;
         count   <= '0;
      end else if (strt_cal) begin
         cal_acc <= '0;
         count   <= '0;
      end else if (state == CAL && vld) begin
         cal_acc <= cal_sum;
         count   <= count + 1'b1;
      end
   // offset is the mean of the calibration window, captured with the final sample folded in
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cal_done <= 1'b0;
         offset   <= '0;
      end else begin
         cal_done <= cal_last;
         if (cal_last) offset <= 16'(cal_sum >>> N);
      end
   // stage 1: compensated rate plus the qualifiers that travel with it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_vld    <= 1'b0;
         comp      <= '0;
         s1_moving <= 1'b0;
         s1_fusion <= 1'b0;
         s1_ir     <= '0;
      end else begin
         s1_vld <= state == RUN && vld && !strt_cal;
         if (vld) begin
            comp      <= comp_nxt;
            s1_moving <= moving;
            s1_fusion <= en_fusion;
            s1_ir     <= IR_Dtrm;
         end
      end
   // stage 2: integrate while moving; rdy marks every completed sample
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rdy         <= 1'b0;
         heading_acc <= '0;
      end else begin
         rdy <= take;
         if (cal_last) heading_acc <= '0;
         else if (take && s1_moving) heading_acc <= acc_nxt;
      end
   assign heading = heading_acc[26:15];
endmodule

// File: tb/tb_gyro_heading_integ.sv
// tb_gyro_heading_integ: directed tables plus randomized traffic against a timestamped reference model
module tb_gyro_heading_integ;
   logic clk = 1'b0, rst_n = 1'b0, strt_cal = 1'b0, vld = 1'b0, moving = 1'b0, en_fusion = 1'b0;
   logic signed [15:0] yaw_rt = '0;
   logic signed [8:0]  IR_Dtrm = '0;
   logic cal_done, rdy;
   logic [11:0] heading;
   int tests = 0, fails = 0, cyc = 0, cd_seen = 0, rdy_seen = 0;
   localparam longint MASK = 64'h7FF_FFFF;

   gyro_heading_integ #(.FAST_SIM(1'b1), .FUS_SHIFT(6)) dut (
      .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld), .yaw_rt(yaw_rt),
      .moving(moving), .en_fusion(en_fusion), .IR_Dtrm(IR_Dtrm),
      .cal_done(cal_done), .rdy(rdy), .heading(heading));

   always #5 clk = ~clk;

   typedef struct { int due; int delta; bit mv; } ev_t;
   ev_t q[$];
   int mode, ccnt;
   longint csum, off, hacc;
   bit e_rdy, e_cd;

   typedef struct { logic [15:0] yaw; bit mv; bit ef; logic [8:0] ir; int reps; logic [11:0] exp_h; } vec_t;
   vec_t tbl[9];

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, a, e);
      end
   endtask

   function automatic void mreset();
      q.delete();
      mode = 0; ccnt = 0; csum = 0; off = 0; hacc = 0; e_rdy = 0; e_cd = 0;
   endfunction

   // Reference: outputs expected in the cycle following the inputs seen at this edge
   function automatic void mstep();
      longint comp;
      e_rdy = 0; e_cd = 0;
      if (strt_cal) begin
         q.delete(); mode = 1; csum = 0; ccnt = 0;
      end else begin
         if (q.size() > 0 && q[0].due == cyc + 1) begin
            e_rdy = 1;
            if (q[0].mv) hacc = (hacc + q[0].delta) & MASK;
            void'(q.pop_front());
         end
         if (vld && mode == 1) begin
            csum += longint'(yaw_rt);
            ccnt++;
            if (ccnt == 256) begin
               off = csum >>> 8; hacc = 0; e_cd = 1; mode = 2;
            end
         end else if (vld && mode == 2) begin
            comp = longint'(yaw_rt) - off;
            if (comp > 32767) comp = 32767;
            if (comp < -32768) comp = -32768;
            if (en_fusion) comp += longint'(IR_Dtrm) * 64;
            q.push_back('{cyc + 2, int'(comp), moving});
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      mstep();
      cyc++;
      #1;
      chk("rdy", rdy, e_rdy);
      chk("cal_done", cal_done, e_cd);
      chk("heading", heading, (hacc >> 15) & 64'hFFF);
      if (cal_done) cd_seen++;
      if (rdy) rdy_seen++;
   endtask

   initial begin
      int r;
      tbl[0] = '{16'h1010, 1'b1, 1'b0, 9'h000, 8, 12'h001};
      tbl[1] = '{16'h1010, 1'b0, 1'b0, 9'h000, 8, 12'h001};
      tbl[2] = '{16'h8000, 1'b1, 1'b0, 9'h000, 1, 12'h000};
      tbl[3] = '{16'h8000, 1'b1, 1'b0, 9'h000, 1, 12'hFFF};
      tbl[4] = '{16'h0010, 1'b1, 1'b1, 9'h100, 2, 12'hFFE};
      tbl[5] = '{16'h0010, 1'b1, 1'b0, 9'h100, 2, 12'hFFE};
      tbl[6] = '{16'h7FFF, 1'b1, 1'b0, 9'h000, 2, 12'hFFF};
      tbl[7] = '{16'h0010, 1'b1, 1'b1, 9'h0FF, 2, 12'h000};
      tbl[8] = '{16'h8000, 1'b0, 1'b1, 9'h100, 3, 12'h000};
      mreset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_heading", heading, 12'h000);
      chk("reset_rdy", rdy, 1'b0);
      chk("reset_cal_done", cal_done, 1'b0);
      rst_n = 1'b1;
      // idle ignores vld
      vld = 1'b1; yaw_rt = 16'h1234; moving = 1'b1;
      repeat (4) tick();
      // calibration over 256 back-to-back samples of 0x0010
      strt_cal = 1'b1; tick(); strt_cal = 1'b0;
      vld = 1'b1; yaw_rt = 16'h0010; cd_seen = 0; rdy_seen = 0;
      repeat (255) tick();
      chk("cal_done_early", cd_seen, 0);
      tick();
      chk("cal_done_t1", cal_done, 1'b1);
      vld = 1'b0;
      repeat (3) tick();
      chk("cal_pulses", cd_seen, 1);
      chk("cal_no_rdy", rdy_seen, 0);
      chk("cal_heading", heading, 12'h000);
      // two-cycle pipe latency
      vld = 1'b1; moving = 1'b1; tick(); vld = 1'b0;
      chk("pipe_t1", rdy, 1'b0);
      tick();
      chk("pipe_t2", rdy, 1'b1);
      tick();
      chk("pipe_t3", rdy, 1'b0);
      // table: integration, hold, saturation, wrap, fusion
      for (int i = 0; i < 9; i++) begin
         yaw_rt = tbl[i].yaw; moving = tbl[i].mv; en_fusion = tbl[i].ef; IR_Dtrm = tbl[i].ir;
         vld = 1'b1; rdy_seen = 0;
         repeat (tbl[i].reps) tick();
         vld = 1'b0;
         repeat (2) tick();
         chk($sformatf("tbl%0d_heading", i), heading, tbl[i].exp_h);
         chk($sformatf("tbl%0d_rdys", i), rdy_seen, tbl[i].reps);
      end
      // restart: only the 256 samples after the second strt_cal count
      en_fusion = 1'b0; cd_seen = 0;
      strt_cal = 1'b1; tick(); strt_cal = 1'b0;
      vld = 1'b1; yaw_rt = 16'h7000;
      repeat (100) tick();
      strt_cal = 1'b1; tick(); strt_cal = 1'b0;
      chk("restart_no_done", cd_seen, 0);
      for (int i = 0; i < 256; i++) begin
         yaw_rt = i[0] ? 16'h0280 : 16'h0180;
         tick();
      end
      vld = 1'b0;
      repeat (2) tick();
      chk("restart_pulses", cd_seen, 1);
      vld = 1'b1; moving = 1'b1; yaw_rt = 16'h1200;
      repeat (8) tick();
      vld = 1'b0;
      repeat (2) tick();
      chk("restart_offset", heading, 12'h001);
      // climb to 0x123 then reset mid-run
      vld = 1'b1; yaw_rt = 16'h4200;
      repeat (580) tick();
      vld = 1'b0;
      repeat (2) tick();
      chk("pre_reset_heading", heading, 12'h123);
      rst_n = 1'b0; mreset();
      #1;
      chk("async_reset_heading", heading, 12'h000);
      @(posedge clk);
      #1 rst_n = 1'b1;
      vld = 1'b1; rdy_seen = 0;
      repeat (10) tick();
      chk("post_reset_no_rdy", rdy_seen, 0);
      // randomized traffic with occasional restarts and saturating extremes
      for (int i = 0; i < 4000; i++) begin
         strt_cal = (i == 0) || ($urandom_range(0, 599) == 0);
         vld = $urandom_range(0, 3) != 0;
         r = $urandom_range(0, 9);
         yaw_rt = r == 0 ? 16'h8000 : r == 1 ? 16'h7FFF : 16'($urandom);
         moving = $urandom_range(0, 3) != 0;
         en_fusion = 1'($urandom_range(0, 1));
         IR_Dtrm = 9'($urandom);
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
